// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller:
// register indices and the request FSM states.
package intc_pkg;

    localparam logic [1:0] INTC_PEND = 2'd0;
    localparam logic [1:0] INTC_MASK = 2'd1;
    localparam logic [1:0] INTC_EDGE = 2'd2;
    localparam logic [1:0] INTC_ISR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder over the enabled
// pending sources.
module intc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [2:0]   idx
);

    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/intc.sv
// Interrupt controller: synchronises up to eight sources,
// latches them in PEND and issues one request at a time.
module intc
    import intc_pkg::*;
#(
    parameter int         N_SRC    = 8,
    parameter logic [7:0] VEC_BASE = 8'h10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [1:0]       addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o,
    output logic             irq_o,
    input  logic             irq_ack_i,
    output logic [7:0]       vec_o
);

    logic [N_SRC-1:0] sync1, sync2, sync3;
    logic [N_SRC-1:0] pend, mask, edge_sel;
    logic [N_SRC-1:0] pend_nxt, rise, w1c, ack_clr, pm;
    logic [2:0]       isr_idx, win_idx;
    logic             win_any;
    logic             wr, rd, ack_take, eoi;
    logic [7:0]       rd_mux;
    intc_state_t      state, state_nxt;

    assign wr       = sel_i & we_i;
    assign rd       = sel_i & ~we_i;
    assign pm       = pend & mask;
    assign rise     = sync2 & ~sync3;
    assign ack_take = (state == REQ) & irq_ack_i & win_any;
    assign eoi      = (state == SERVICE) & wr
                    & (addr_i == INTC_ISR);
    assign irq_o    = (state == REQ);

    intc_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .req (pm),
        .any (win_any),
        .idx (win_idx)
    );

    // A fresh rising edge outranks any clear in the same cycle.
    always_comb begin
        w1c = '0;
        if (wr && addr_i == INTC_PEND)
            w1c = wdata_i[N_SRC-1:0] & edge_sel;
        ack_clr = '0;
        if (ack_take)
            ack_clr = edge_sel & (N_SRC'(1) << win_idx);
        pend_nxt = (edge_sel & ((pend & ~w1c & ~ack_clr) | rise))
                 | (~edge_sel & sync2);
    end

    always_comb begin
        rd_mux = '0;
        unique case (addr_i)
            INTC_PEND: rd_mux = 8'(pend);
            INTC_MASK: rd_mux = 8'(mask);
            INTC_EDGE: rd_mux = 8'(edge_sel);
            INTC_ISR:  rd_mux = {state == SERVICE, 4'b0, isr_idx};
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_any) state_nxt = REQ;
            REQ: begin
                if (ack_take)      state_nxt = SERVICE;
                else if (!win_any) state_nxt = IDLE;
            end
            SERVICE: if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            isr_idx  <= '0;
            vec_o    <= '0;
            rdata_o  <= '0;
        end else begin
            sync1 <= src_i;
            sync2 <= sync1;
            sync3 <= sync2;
            pend  <= pend_nxt;
            if (wr && addr_i == INTC_MASK)
                mask <= wdata_i[N_SRC-1:0];
            if (wr && addr_i == INTC_EDGE)
                edge_sel <= wdata_i[N_SRC-1:0];
            if (ack_take) begin
                isr_idx <= win_idx;
                vec_o   <= VEC_BASE + 8'(win_idx);
            end
            if (rd)
                rdata_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_intc.sv
// Directed and randomized bench for intc against a
// behavioural model of the interrupt rules.
module tb_intc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src = '0;
    logic       sel = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       irq;
    logic       ack = 1'b0;
    logic [7:0] vec;

    int checks = 0;
    int errors = 0;

    // model state
    bit [7:0] m_pend, m_mask, m_edge, m_vec, m_rdata;
    bit [7:0] h0, h1, h2;
    bit [2:0] m_idx;
    bit       m_req, m_busy;

    always #5 clk = ~clk;

    intc #(
        .N_SRC    (8),
        .VEC_BASE (8'h10)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .src_i     (src),
        .sel_i     (sel),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .irq_o     (irq),
        .irq_ack_i (ack),
        .vec_o     (vec)
    );

    task automatic chk(string tag, logic [7:0] obs,
                       logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 0;
        m_vec = 0; m_rdata = 0; m_idx = 0;
        m_req = 0; m_busy = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    // One clock of the rules: h1 is the synchronised level,
    // h2 its previous value.
    task automatic model_step();
        bit [7:0] pm, rise, np;
        int       w;
        bit       wr, ack_ok, eoi;
        pm     = m_pend & m_mask;
        w      = lowest(pm);
        rise   = h1 & ~h2;
        wr     = sel && we;
        ack_ok = m_req && ack && (w >= 0);
        eoi    = wr && addr == 2'd3 && m_busy;
        if (sel && !we) begin
            case (addr)
                2'd0: m_rdata = m_pend;
                2'd1: m_rdata = m_mask;
                2'd2: m_rdata = m_edge;
                default: m_rdata = {m_busy, 4'b0, m_idx};
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                np[i] = m_pend[i];
                if (wr && addr == 2'd0 && wdata[i]) np[i] = 0;
                if (ack_ok && w == i) np[i] = 0;
                if (rise[i]) np[i] = 1;
            end else begin
                np[i] = h1[i];
            end
        end
        if (ack_ok) begin
            m_idx = 3'(w);
            m_vec = 8'h10 + 8'(w);
        end
        if (m_busy) begin
            if (eoi) m_busy = 0;
        end else if (m_req) begin
            if (ack_ok) begin
                m_req = 0;
                m_busy = 1;
            end else if (w < 0) begin
                m_req = 0;
            end
        end else if (pm != 0) begin
            m_req = 1;
        end
        if (wr && addr == 2'd1) m_mask = wdata;
        if (wr && addr == 2'd2) m_edge = wdata;
        m_pend = np;
        h2 = h1;
        h1 = h0;
        h0 = src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", 8'(irq), 8'(m_req));
        chk("vec", vec, m_vec);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        tick();
        sel = 0; we = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        sel = 1; we = 0; addr = a;
        tick();
        sel = 0;
        v = rdata;
    endtask

    task automatic pulse_ack();
        ack = 1;
        tick();
        ack = 0;
    endtask

    initial begin
        logic [7:0] v;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_vec", vec, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        rst = 0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("rst_reg", v, 8'h00);
        end

        // basic edge request
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h01);
        src = 8'h01;
        ticks(3);
        chk("basic_early", 8'(irq), 8'h00);
        src = 8'h00;
        tick();
        chk("basic_irq", 8'(irq), 8'h01);
        pulse_ack();
        chk("basic_vec", vec, 8'h10);
        chk("basic_irq_off", 8'(irq), 8'h00);
        rd(2'd0, v);
        chk("basic_pend", v, 8'h00);
        rd(2'd3, v);
        chk("basic_isr", v, 8'h80);
        wr(2'd3, 8'h00);

        // priority
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'hFF);
        src = 8'h24;
        ticks(4);
        chk("prio_irq", 8'(irq), 8'h01);
        pulse_ack();
        chk("prio_vec1", vec, 8'h12);
        wr(2'd3, 8'h00);
        tick();
        chk("prio_rearm", 8'(irq), 8'h01);
        pulse_ack();
        chk("prio_vec2", vec, 8'h15);
        wr(2'd3, 8'h00);
        src = 8'h00;
        ticks(3);

        // masking
        wr(2'd1, 8'h00);
        src = 8'h08;
        ticks(4);
        rd(2'd0, v);
        chk("mask_pend", v, 8'h08);
        chk("mask_irq", 8'(irq), 8'h00);
        wr(2'd1, 8'h08);
        tick();
        chk("mask_irq_on", 8'(irq), 8'h01);
        pulse_ack();
        chk("mask_vec", vec, 8'h13);
        wr(2'd3, 8'h00);
        src = 8'h00;
        ticks(3);

        // level source
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h02);
        src = 8'h02;
        ticks(4);
        pulse_ack();
        chk("lvl_vec", vec, 8'h11);
        wr(2'd3, 8'h00);
        tick();
        chk("lvl_rearm", 8'(irq), 8'h01);
        src = 8'h00;
        ticks(4);
        chk("lvl_drop", 8'(irq), 8'h00);
        rd(2'd0, v);
        chk("lvl_pend", v, 8'h00);

        // withdraw and ignore
        wr(2'd2, 8'h01);
        wr(2'd1, 8'h01);
        src = 8'h01;
        ticks(4);
        chk("wd_irq", 8'(irq), 8'h01);
        src = 8'h00;
        wr(2'd0, 8'h01);
        tick();
        chk("wd_irq_off", 8'(irq), 8'h00);
        pulse_ack();
        chk("wd_vec", vec, 8'h11);
        rd(2'd3, v);
        chk("wd_isr", v, 8'h01);

        // reset in SERVICE
        rd(2'd1, v);
        src = 8'h01;
        ticks(4);
        pulse_ack();
        chk("svc_vec", vec, 8'h10);
        #4;
        rst = 1;
        #1;
        chk("arst_irq", 8'(irq), 8'h00);
        chk("arst_vec", vec, 8'h00);
        chk("arst_rdata", rdata, 8'h00);
        model_reset();
        src = 8'h00;
        @(posedge clk);
        #1;
        rst = 0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("arst_reg", v, 8'h00);
        end

        // randomized traffic
        wr(2'd2, 8'($urandom));
        wr(2'd1, 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) src = 8'($urandom);
            ack   = ($urandom_range(0, 3) == 0);
            sel   = ($urandom_range(0, 2) == 0);
            we    = 1'($urandom);
            addr  = 2'($urandom);
            wdata = 8'($urandom);
            tick();
        end
        ack = 0;
        sel = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/intc.md
# intc

Interrupt controller for the 8-bit processor core: it collects up to eight external interrupt sources and presents a single registered request to the CPU's `irq_i`. It accepts the CPU's acknowledge, supplies the vector of the winning source, and holds further requests off until the CPU signals end-of-interrupt. It sits in `top` beside the memory, and its registers are memory-mapped on the CPU data bus.

## Interface
- `N_SRC`, default 8: number of interrupt sources (1..8).
- `VEC_BASE`, default 8'h10: vector of source 0. Source *i* gets `VEC_BASE + i`.
- `clk_i`  in  1  the single system clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `src_i`  in  N_SRC  raw interrupt sources, asynchronous to `clk_i`.
- `sel_i`  in  1  register access strobe, one cycle per access.
- `we_i`  in  1  1 = write, 0 = read; qualified by `sel_i`.
- `addr_i`  in  2  register index.
- `wdata_i`  in  8  write data.
- `rdata_o`  out  8  read data, valid the cycle after `sel_i && !we_i`.
- `irq_o`  out  1  interrupt request to the CPU `irq_i`.
- `irq_ack_i`  in  1  CPU acknowledge, one-cycle pulse.
- `vec_o`  out  8  vector of the acknowledged source.

## Operation
- **Register map:**
  - 0 PEND: read returns pending bits; write-1-to-clear, effective for edge sources only.
  - 1 MASK: read/write; 1 = source enabled.
  - 2 EDGE: read/write; 1 = rising-edge source, 0 = level source.
  - 3 ISR: read returns `{active, 4'b0, idx[2:0]}`; any write is EOI.
- Unused bits (≥ `N_SRC`) read 0 and ignore writes.
- **Source path:** each source passes a 2-flop synchroniser.
  - Edge source: the pending bit sets on a synchronised 0→1 transition and stays set until acknowledged or W1C-cleared.
  - Level source: the pending bit equals the synchronised level and cannot be cleared by W1C.
- **Priority:** the lowest index among `PEND & MASK` wins.
- **FSM:**
  - IDLE: if `PEND & MASK` ≠ 0, go to REQ.
  - REQ: `irq_o` = 1.
    - On `irq_ack_i`: latch the winner index into ISR and `vec_o`, clear the winner's pending bit if it is an edge source, then go to SERVICE.
    - If `PEND & MASK` becomes 0 before the ack: return to IDLE; `irq_o` drops.
  - SERVICE: `irq_o` = 0. A write to ISR (EOI) returns to IDLE.
- `irq_ack_i` outside REQ is ignored.
- EOI outside SERVICE is ignored.
- The winner is recomputed every cycle in REQ. `vec_o` reflects the winner at the ack cycle, not at the cycle `irq_o` rose.
- No nesting: new requests in SERVICE stay pending and are issued after EOI.

## Timing
- **Reset:** `irq_o`=0, `vec_o`=0, `rdata_o`=0, PEND=MASK=EDGE=0, ISR=0, synchroniser flops 0, state IDLE.
- **Edge-source latency:** `src_i` rises at edge *n*; synchronised at *n*+2; PEND bit set at *n*+3; `irq_o` = 1 at *n*+4 (if masked-in and the FSM is in IDLE).
- **Ack:** `irq_ack_i` high at edge *k* gives `vec_o` valid and `irq_o` = 0 after *k*. `vec_o` holds until the next ack.
- **EOI:** at edge *k*, FSM is in IDLE after *k*. `irq_o` may re-assert at *k*+1 if anything is pending.
- **Simultaneous events:**
  - Edge set and W1C on the same bit in the same cycle: set wins.
  - Edge set and ack-clear on the same bit in the same cycle: set wins, and the bit stays pending.
  - MASK write and ack in the same cycle: the ack uses the pre-write mask.
- **Reads:** 1-cycle latency. `rdata_o` holds its last value when not reading.
- **Asynchronous reset mid-SERVICE:** everything returns to reset values immediately; `irq_o` drops without waiting for the clock.

## Structure
- Package `intc_pkg`:
  - register index constants `INTC_PEND`, `INTC_MASK`, `INTC_EDGE`, `INTC_ISR`;
  - FSM enum `intc_state_t` {IDLE, REQ, SERVICE}.
- Sub-module `intc_prio_enc`: combinational lowest-index-first encoder with `any` and `idx` outputs.
- The synchroniser, registers and FSM stay in `intc`.

## Test plan
- **Basic edge request:** reset; MASK=01, EDGE=01; pulse `src_i[0]` for 3 cycles → `irq_o`=1 four cycles after the rise; ack → `vec_o`=8'h10, `irq_o`=0, PEND=00, ISR read = 8'h80.
- **Priority:** MASK=FF, EDGE=FF; raise src 5 and src 2 together → ack gives `vec_o`=8'h12; EOI → `irq_o` re-asserts; ack gives 8'h15.
- **Masking:** MASK=00; edge on src 3 → PEND=08 and `irq_o` stays 0; write MASK=08 → `irq_o`=1 two cycles later.
- **Level source:** EDGE=00, MASK=02; hold `src_i[1]` high → ack gives 8'h11; after EOI `irq_o` rises again; drop src → PEND=00 and `irq_o`=0.
- **Withdraw and ignore:** in REQ, W1C PEND=01 → `irq_o`=0 and FSM in IDLE; a following `irq_ack_i` leaves `vec_o` unchanged.
- **Reset in SERVICE:** assert `rst_i` mid-cycle → `irq_o`, `vec_o` and all registers read 0, with no clock edge required.
